led_chain_rx: RTL and testbench

- Parametrised successor to the single-pixel LED controller: a WS281x-style one-wire serial receiver.
- Decodes a stream of pulse-width-coded bits and captures the first NUM_PIXELS pixels of BITS_PER_PIXEL bits each (e.g. 24 for RGB, 32 for RGBW).
- Forwards every later bit downstream, commits the captured frame on the latch (long-low) interval, and flags malformed frames.
- Sits between the board pin and the LED driver/PWM logic; replaces the separate synchronizer/timer/decoder/shift-register chain with one configurable block.

---
 rtl/led_chain_rx.sv | 191 +++++++++++++++++++
 tb/tb_led_chain_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chain_rx.sv
// WS281x-style one-wire receiver: captures NUM_PIXELS pixels, forwards later bits, commits on latch.
// Optional input stability filter: define LED_CHAIN_RX_DEBOUNCE_EN (uses DEBOUNCE_CYCLES).
module led_chain_rx #(
    parameter int BITS_PER_PIXEL  = 24,
    parameter int NUM_PIXELS      = 2,
    parameter int T1_THRESHOLD    = 30,
    parameter int MIN_HIGH        = 5,
    parameter int MAX_HIGH        = 60,
    parameter int RESET_CYCLES    = 2500,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_serial,
    output logic                                 o_serial,
    output logic [NUM_PIXELS*BITS_PER_PIXEL-1:0] o_pixels,
    output logic [$clog2(NUM_PIXELS+1)-1:0]      o_pixel_count,
    output logic                                 o_frame_valid,
    output logic                                 o_frame_err,
    output logic                                 o_passthru_en
);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL);
    localparam int PW = $clog2(NUM_PIXELS + 1);
    localparam logic [CW-1:0] C_T1       = CW'(T1_THRESHOLD);
    localparam logic [CW-1:0] C_MINH     = CW'(MIN_HIGH);
    localparam logic [CW-1:0] C_MAXH     = CW'(MAX_HIGH);
    localparam logic [CW-1:0] C_RC       = CW'(RESET_CYCLES);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(BITS_PER_PIXEL - 1);
    localparam logic [PW-1:0] C_LAST_PIX = PW'(NUM_PIXELS - 1);
    localparam logic [PW-1:0] C_ALL_PIX  = PW'(NUM_PIXELS);

    if (BITS_PER_PIXEL < 8 || BITS_PER_PIXEL > 32 || NUM_PIXELS < 1 || NUM_PIXELS > 64 ||
        MAX_HIGH >= RESET_CYCLES || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("led_chain_rx: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_PASS, S_LATCH} state_t;

    state_t                                      r_state, w_next;
    logic                                        r_s1, r_s2, r_d;
    logic                                        w_din, w_rise, w_fall;
    logic [CW-1:0]                               r_cnt;
    logic [BITS_PER_PIXEL-2:0]                   r_shift;
    logic [BW-1:0]                               r_bitcnt;
    logic [PW-1:0]                               r_pix_idx, r_pix_cnt;
    logic [NUM_PIXELS-1:0][BITS_PER_PIXEL-1:0]   r_shadow, r_pixels;
    logic                                        r_err, r_passthru, r_fv, r_ferr, r_ser;
    logic                                        w_shift_en, w_err_set, w_bit, w_wrap, w_last, w_commit;
    logic [BITS_PER_PIXEL-1:0]                   w_word;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_serial;
            r_s2 <= r_s1;
        end
    end

`ifdef LED_CHAIN_RX_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] r_db_cnt;
    logic          r_filt;

    // The filtered level follows the synced input only after it disagrees for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_s2 == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt <= '0;
            r_filt   <= r_s2;
        end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
        end
    end
    assign w_din = r_filt;
`else
    assign w_din = r_s2;
`endif

    assign w_rise   = w_din & ~r_d;
    assign w_fall   = ~w_din & r_d;
    assign w_bit    = (r_cnt >= C_T1);
    assign w_word   = {r_shift, w_bit};
    assign w_wrap   = (r_bitcnt == C_LAST_BIT);
    assign w_last   = (r_pix_idx == C_LAST_PIX);
    assign w_commit = (r_pix_idx != '0) || (r_bitcnt != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            S_IDLE: if (w_rise) w_next = S_HIGH;
            S_HIGH: begin
                if (w_fall) begin
                    if (r_cnt < C_MINH)       w_err_set  = 1'b1;
                    else if (r_cnt <= C_MAXH) w_shift_en = 1'b1;
                    // The last captured bit hands the rest of the frame to passthrough timing.
                    if (r_cnt >= C_MINH && r_cnt <= C_MAXH && w_wrap && w_last) w_next = S_PASS;
                    else                                                        w_next = S_LOW;
                end else if (r_cnt > C_MAXH) begin
                    w_err_set = 1'b1;
                end
            end
            S_LOW: begin
                if (w_rise)              w_next = S_HIGH;
                else if (r_cnt == C_RC)  w_next = S_LATCH;
            end
            S_PASS: if (!w_din && !r_d && r_cnt == C_RC) w_next = S_LATCH;
            S_LATCH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_d        <= 1'b0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_pix_idx  <= '0;
            r_pix_cnt  <= '0;
            r_err      <= 1'b0;
            r_passthru <= 1'b0;
            r_fv       <= 1'b0;
            r_ferr     <= 1'b0;
            r_ser      <= 1'b0;
        end else begin
            r_d   <= w_din;
            r_ser <= r_passthru & r_d;
            if (w_rise || w_fall)  r_cnt <= '0;
            else if (r_cnt != C_RC) r_cnt <= r_cnt + CW'(1);
            if (w_shift_en) begin
                r_shift <= w_word[BITS_PER_PIXEL-2:0];
                if (w_wrap) begin
                    r_bitcnt  <= '0;
                    r_pix_idx <= r_pix_idx + PW'(1);
                end else begin
                    r_bitcnt  <= r_bitcnt + BW'(1);
                end
            end
            if (w_err_set) r_err <= 1'b1;
            r_passthru <= (r_pix_idx == C_ALL_PIX);
            r_fv       <= 1'b0;
            if (r_state == S_LATCH) begin
                if (w_commit) begin
                    r_pix_cnt <= r_pix_idx;
                    r_fv      <= 1'b1;
                    r_ferr    <= r_err | (r_bitcnt != '0);
                end
                r_bitcnt   <= '0;
                r_pix_idx  <= '0;
                r_err      <= 1'b0;
                r_passthru <= 1'b0;
            end
        end
    end

    // Only slots completed in this frame are committed; the rest keep their last committed value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow <= '0;
            r_pixels <= '0;
        end else begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (w_shift_en && w_wrap && r_pix_idx == PW'(i))
                    r_shadow[i] <= w_word;
                if (r_state == S_LATCH && w_commit && PW'(i) < r_pix_idx)
                    r_pixels[NUM_PIXELS-1-i] <= r_shadow[i];
            end
        end
    end

    assign o_serial      = r_ser;
    assign o_pixels      = r_pixels;
    assign o_pixel_count = r_pix_cnt;
    assign o_frame_valid = r_fv;
    assign o_frame_err   = r_ferr;
    assign o_passthru_en = r_passthru;
endmodule

// File: tb/tb_led_chain_rx.sv
// Directed bench for led_chain_rx with a frame-level reference model and a per-cycle compare process.
module tb_led_chain_rx;
    localparam int BPP  = 24;
    localparam int NP   = 2;
    localparam int T1   = 30;
    localparam int MINH = 5;
    localparam int MAXH = 60;
`ifdef LED_CHAIN_RX_DEBOUNCE_EN
    localparam int LAT = 4 + 3;
`else
    localparam int LAT = 4;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      ser_in = 1'b0;
    logic                      o_ser, o_fv, o_ferr, o_pt;
    logic [NP*BPP-1:0]         o_pix;
    logic [$clog2(NP+1)-1:0]   o_cnt;

    led_chain_rx dut (
        .i_clk(clk), .i_reset(rst), .i_serial(ser_in), .o_serial(o_ser),
        .o_pixels(o_pix), .o_pixel_count(o_cnt), .o_frame_valid(o_fv),
        .o_frame_err(o_ferr), .o_passthru_en(o_pt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frame contents from pulse high-times alone.
    typedef struct { logic [NP*BPP-1:0] pix; int cnt; bit err; } exp_t;
    exp_t               exp_q[$];
    exp_t               e_cur;
    logic [BPP-1:0]     m_pix [NP];
    logic [NP*BPP-1:0]  m_comm = '0;
    int                 m_nbits = 0;
    bit                 m_err = 1'b0;

    task automatic model_pulse(input int h);
        if (m_nbits >= NP*BPP) return;
        if (h < MINH || h > MAXH) m_err = 1'b1;
        else begin
            m_pix[m_nbits / BPP][BPP-1 - (m_nbits % BPP)] = (h >= T1);
            m_nbits++;
        end
    endtask

    task automatic model_latch();
        int full;
        bit part;
        exp_t e;
        full = m_nbits / BPP;
        part = (m_nbits % BPP) != 0;
        if (full > 0 || part) begin
            for (int i = 0; i < full; i++) m_comm[(NP-1-i)*BPP +: BPP] = m_pix[i];
            e.pix = m_comm;
            e.cnt = full;
            e.err = m_err || part;
            exp_q.push_back(e);
        end
        m_nbits = 0;
        m_err   = 1'b0;
    endtask

    // Compare process and observation tallies.
    logic [NP*BPP-1:0] cur_pix = '0;
    int                cur_cnt = 0;
    int                fv_cnt = 0;
    logic [NP*BPP-1:0] last_pix = '0;
    int                last_cnt = 0;
    bit                last_err = 1'b0;
    int                ser_rises = 0, ser_bad_w = 0, ser_first = -1, ser_w = 0;
    logic              ser_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_fv) begin
                fv_cnt++;
                last_pix = o_pix;
                last_cnt = int'(o_cnt);
                last_err = o_ferr;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got frame_valid=1 expected no commit");
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("model_pixels", o_pix, e_cur.pix);
                    chk("model_count", o_cnt, e_cur.cnt);
                    chk("model_err", o_ferr, e_cur.err);
                    cur_pix = e_cur.pix;
                    cur_cnt = e_cur.cnt;
                end
            end
            chk("held_pixels", o_pix, cur_pix);
            chk("held_count", o_cnt, cur_cnt);
            if (o_ser && !ser_prev) begin
                ser_rises++;
                if (ser_first < 0) ser_first = cyc;
                ser_w = 0;
            end
            if (o_ser) ser_w++;
            if (!o_ser && ser_prev && ser_w != 40) ser_bad_w++;
            ser_prev = o_ser;
        end
    end

    task automatic hold(input logic v, input int n);
        ser_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        model_pulse(b ? 40 : 20);
        hold(1'b1, b ? 40 : 20);
        hold(1'b0, b ? 22 : 42);
    endtask

    task automatic send_word(input logic [BPP-1:0] w, input int nb);
        for (int i = 0; i < nb; i++) send_bit(w[BPP-1-i]);
    endtask

    task automatic send_spiky(input logic [BPP-1:0] w);
        for (int i = 0; i < BPP; i++) begin
            model_pulse(w[BPP-1-i] ? 40 : 20);
            hold(1'b1, w[BPP-1-i] ? 40 : 20);
            if (w[BPP-1-i]) begin hold(1'b0, 8);  hold(1'b1, 2); hold(1'b0, 12); end
            else            begin hold(1'b0, 20); hold(1'b1, 2); hold(1'b0, 20); end
        end
    endtask

    task automatic latch();
        model_latch();
        hold(1'b0, 2600);
    endtask

    task automatic clear_ser();
        ser_rises = 0;
        ser_bad_w = 0;
        ser_first = -1;
    endtask

    int fv0, drive_cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pixels", o_pix, 0);
        chk("reset_count", o_cnt, 0);
        chk("reset_valid", o_fv, 0);
        chk("reset_err", o_ferr, 0);
        chk("reset_passthru", o_pt, 0);
        chk("reset_serial", o_ser, 0);
        rst = 1'b0;
        hold(1'b0, 20);

        // Glitch only: no pixels and no partial bits, so nothing commits.
        fv0 = fv_cnt;
        model_pulse(3);
        hold(1'b1, 3);
        hold(1'b0, 22);
        latch();
        chk("empty_no_commit", fv_cnt - fv0, 0);

        // Two pixels, no passthrough.
        fv0 = fv_cnt;
        clear_ser();
        send_word(24'hA5C3F0, 24);
        send_word(24'h123456, 24);
        latch();
        chk("f1_one_pulse", fv_cnt - fv0, 1);
        chk("f1_pixels", last_pix, 48'hA5C3F0_123456);
        chk("f1_count", last_cnt, 2);
        chk("f1_err", last_err, 0);
        chk("f1_serial_quiet", ser_rises, 0);

        // Three pixels: third is forwarded.
        fv0 = fv_cnt;
        send_word(24'h0F0F0F, 24);
        send_word(24'h00FF00, 23);
        chk("f2_pt_before_last", o_pt, 0);
        send_bit(1'b0);
        chk("f2_pt_after_capture", o_pt, 1);
        clear_ser();
        drive_cyc = cyc;
        send_word(24'hFFFFFF, 24);
        latch();
        chk("f2_one_pulse", fv_cnt - fv0, 1);
        chk("f2_pixels", last_pix, 48'h0F0F0F_00FF00);
        chk("f2_count", last_cnt, 2);
        chk("f2_err", last_err, 0);
        chk("f2_fwd_pulses", ser_rises, 24);
        chk("f2_fwd_widths_bad", ser_bad_w, 0);
        chk("f2_fwd_delay", ser_first - drive_cyc, LAT);
        chk("f2_pt_cleared", o_pt, 0);

        // One pixel plus a partial pixel.
        fv0 = fv_cnt;
        send_word(24'h3C3C3C, 24);
        send_word(24'hFFC000, 10);
        latch();
        chk("f3_one_pulse", fv_cnt - fv0, 1);
        chk("f3_pixels", last_pix, 48'h3C3C3C_00FF00);
        chk("f3_count", last_cnt, 1);
        chk("f3_err", last_err, 1);

        // Glitch and over-long pulse mid-pixel are flagged and not shifted.
        fv0 = fv_cnt;
        send_word(24'hABC000, 12);
        model_pulse(3);
        hold(1'b1, 3);
        hold(1'b0, 22);
        model_pulse(70);
        hold(1'b1, 70);
        hold(1'b0, 22);
        send_word(24'hDEF000, 12);
        latch();
        chk("f4_one_pulse", fv_cnt - fv0, 1);
        chk("f4_pixels", last_pix, 48'hABCDEF_00FF00);
        chk("f4_count", last_cnt, 1);
        chk("f4_err", last_err, 1);

        // Reset during bit 12 of pixel 0.
        fv0 = fv_cnt;
        send_word(24'h5A5A5A, 11);
        hold(1'b1, 12);
        rst = 1'b1;
        ser_in = 1'b0;
        exp_q.delete();
        cur_pix = '0;
        cur_cnt = 0;
        m_comm  = '0;
        m_nbits = 0;
        m_err   = 1'b0;
        #2;
        chk("mid_rst_pixels", o_pix, 0);
        chk("mid_rst_count", o_cnt, 0);
        chk("mid_rst_valid", o_fv, 0);
        chk("mid_rst_err", o_ferr, 0);
        chk("mid_rst_passthru", o_pt, 0);
        chk("mid_rst_serial", o_ser, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 50);
        chk("mid_rst_no_commit", fv_cnt - fv0, 0);
        send_word(24'h111111, 24);
        send_word(24'h222222, 24);
        latch();
        chk("f5_one_pulse", fv_cnt - fv0, 1);
        chk("f5_pixels", last_pix, 48'h111111_222222);
        chk("f5_count", last_cnt, 2);
        chk("f5_err", last_err, 0);

`ifdef LED_CHAIN_RX_DEBOUNCE_EN
        // Two-clock spikes in every low phase are filtered out.
        fv0 = fv_cnt;
        send_spiky(24'hC3C3C3);
        send_spiky(24'h3C3C3C);
        latch();
        chk("f6_one_pulse", fv_cnt - fv0, 1);
        chk("f6_pixels", last_pix, 48'hC3C3C3_3C3C3C);
        chk("f6_count", last_cnt, 2);
        chk("f6_err", last_err, 0);
`endif

        hold(1'b0, 10);
        chk("model_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
